button_event: RTL and testbench



---
 rtl/button_event.sv | 167 ++++++++++++++++
 tb/tb_button_event.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Classifies a debounced, clk-synchronous button level into one-cycle event pulses.
// release/repeat are SV keywords, so those ports carry a _pulse suffix.
module button_event #(
  parameter int LONG_CYCLES   = 1000000,
  parameter int DOUBLE_CYCLES = 300000,
  parameter int REPEAT_CYCLES = 200000
) (
  input  logic clk,
  input  logic nreset,
  input  logic en,
  input  logic in,
  output logic press,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click,
  output logic held
);

  localparam int MAX_LD  = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
  localparam int MAX_ALL = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] DBL_LAST  = (DOUBLE_CYCLES == 0) ? '0 : CW'(DOUBLE_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = (REPEAT_CYCLES == 0) ? '0 : CW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          in_q, rise, fall;
  logic          press_d, release_d, short_d, long_d, repeat_d, double_d, held_d;

  assign rise    = in & ~in_q;
  assign fall    = ~in & in_q;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    double_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = CW'(1);
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        // a fall on the threshold edge takes the short path
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          if (DOUBLE_CYCLES == 0) begin
            short_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_SECOND;
          end
        end else if (in) begin
          if (cnt == LONG_LAST) begin
            long_d  = 1'b1;
            cnt_d   = '0;
            state_d = LONG_HELD;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      LONG_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (REPEAT_CYCLES != 0) begin
          if (cnt == REP_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT_SECOND: begin
        // a rise on the timeout edge still counts as a double click
        if (rise) begin
          double_d = 1'b1;
          press_d  = 1'b1;
          cnt_d    = '0;
          state_d  = SECOND_PRESSED;
        end else if (cnt == DBL_LAST) begin
          short_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      double_d  = 1'b0;
    end

    // held follows a tracked press, so enabling during a hold does not assert it
    held_d = (state_d == PRESSED) || (state_d == LONG_HELD) || (state_d == SECOND_PRESSED);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      in_q          <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      double_click  <= 1'b0;
      held          <= 1'b0;
    end else begin
      in_q          <= in;
      state         <= state_d;
      cnt           <= cnt_d;
      press         <= press_d;
      release_pulse <= release_d;
      short_press   <= short_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
      double_click  <= double_d;
      held          <= held_d;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Table-driven bench for button_event (LONG=8, DOUBLE=6, REPEAT=4) plus a DOUBLE=0 build.
// Output vectors are {press, release, short, long, repeat, double, held}.
module tb_button_event;

  logic clk = 1'b0;
  logic nreset, en, in;
  logic press, release_pulse, short_press, long_press, repeat_pulse, double_click, held;
  logic n_press, n_release, n_short, n_long, n_repeat, n_double, n_held;
  logic [6:0] dut_o, nd_o;

  localparam logic [6:0] P  = 7'b1000000;
  localparam logic [6:0] R  = 7'b0100000;
  localparam logic [6:0] S  = 7'b0010000;
  localparam logic [6:0] L  = 7'b0001000;
  localparam logic [6:0] RP = 7'b0000100;
  localparam logic [6:0] D  = 7'b0000010;
  localparam logic [6:0] H  = 7'b0000001;
  localparam logic [6:0] Z  = 7'b0000000;

  button_event #(.LONG_CYCLES(8), .DOUBLE_CYCLES(6), .REPEAT_CYCLES(4)) u_dut (
    .clk(clk), .nreset(nreset), .en(en), .in(in),
    .press(press), .release_pulse(release_pulse), .short_press(short_press),
    .long_press(long_press), .repeat_pulse(repeat_pulse), .double_click(double_click),
    .held(held)
  );

  button_event #(.LONG_CYCLES(8), .DOUBLE_CYCLES(0), .REPEAT_CYCLES(4)) u_nd (
    .clk(clk), .nreset(nreset), .en(en), .in(in),
    .press(n_press), .release_pulse(n_release), .short_press(n_short),
    .long_press(n_long), .repeat_pulse(n_repeat), .double_click(n_double),
    .held(n_held)
  );

  assign dut_o = {press, release_pulse, short_press, long_press, repeat_pulse, double_click, held};
  assign nd_o  = {n_press, n_release, n_short, n_long, n_repeat, n_double, n_held};

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       in;
    logic [6:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic e, input logic i, input logic [6:0] x, input string tag);
    vec_t v;
    v.en = e; v.in = i; v.exp = x; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic addn(input logic e, input logic i, input logic [6:0] x, input int n,
                      input string tag);
    for (int k = 0; k < n; k++) add(e, i, x, tag);
  endtask

  task automatic check(input string tag, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", tag, act, exp);
  endtask

  task automatic step(input logic e, input logic i);
    @(negedge clk);
    en = e;
    in = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: short press, timeout 6 cycles after release
    add(1, 1, P | H, "t1_press");   addn(1, 1, H, 2, "t1_hold");
    add(1, 0, R, "t1_release");     addn(1, 0, Z, 5, "t1_wait");
    add(1, 0, S, "t1_short");       addn(1, 0, Z, 3, "t1_quiet");
    // 2: long press with repeat every 4
    add(1, 1, P | H, "t2_press");   addn(1, 1, H, 6, "t2_hold");
    add(1, 1, L | H, "t2_long");
    for (int k = 0; k < 3; k++) begin
      addn(1, 1, H, 3, "t2_lheld");
      add(1, 1, RP | H, "t2_repeat");
    end
    add(1, 0, R, "t2_release");     addn(1, 0, Z, 8, "t2_no_short");
    // 3: double click
    add(1, 1, P | H, "t3_press");   add(1, 1, H, "t3_hold");
    add(1, 0, R, "t3_release");     addn(1, 0, Z, 2, "t3_gap");
    add(1, 1, D | P | H, "t3_double"); add(1, 1, H, "t3_hold2");
    add(1, 0, R, "t3_release2");    addn(1, 0, Z, 8, "t3_no_short");
    // 4a: rise on the timeout edge wins
    add(1, 1, P | H, "t4a_press");  add(1, 1, H, "t4a_hold");
    add(1, 0, R, "t4a_release");    addn(1, 0, Z, 5, "t4a_gap");
    add(1, 1, D | P | H, "t4a_rise_on_timeout");
    add(1, 0, R, "t4a_release2");   addn(1, 0, Z, 8, "t4a_no_short");
    // 4b: one more low sample gives short_press, then a fresh press
    add(1, 1, P | H, "t4b_press");  add(1, 1, H, "t4b_hold");
    add(1, 0, R, "t4b_release");    addn(1, 0, Z, 5, "t4b_gap");
    add(1, 0, S, "t4b_timeout");    add(1, 1, P | H, "t4b_new_press");
    add(1, 0, R, "t4b_release2");   addn(1, 0, Z, 5, "t4b_gap2");
    add(1, 0, S, "t4b_short2");     addn(1, 0, Z, 2, "t4b_quiet");
    // 4c: 7 high samples stays short
    add(1, 1, P | H, "t4c_press");  addn(1, 1, H, 6, "t4c_hold");
    add(1, 0, R, "t4c_hold7_release"); addn(1, 0, Z, 5, "t4c_gap");
    add(1, 0, S, "t4c_short");      addn(1, 0, Z, 2, "t4c_quiet");
    // 4d: 8 high samples is long
    add(1, 1, P | H, "t4d_press");  addn(1, 1, H, 6, "t4d_hold");
    add(1, 1, L | H, "t4d_long8");  add(1, 0, R, "t4d_release");
    addn(1, 0, Z, 8, "t4d_no_short");
    // 6a: en low suppresses everything
    for (int k = 0; k < 4; k++) begin
      add(0, 1, Z, "t6a_en_off_hi");
      add(0, 0, Z, "t6a_en_off_lo");
    end
    addn(1, 0, Z, 2, "t6a_quiet");
    // 6b: enabling while held does not press
    addn(0, 1, Z, 2, "t6b_off_hi");
    addn(1, 1, Z, 3, "t6b_en_rise_held");
    add(1, 0, Z, "t6b_fall_idle");  add(1, 1, P | H, "t6b_real_press");
    add(1, 0, R, "t6b_release");    addn(1, 0, Z, 5, "t6b_gap");
    add(1, 0, S, "t6b_short");      addn(1, 0, Z, 2, "t6b_quiet");
    // 6c: en dropping mid-press abandons silently
    add(1, 1, P | H, "t6c_press");  add(1, 1, H, "t6c_hold");
    add(0, 1, Z, "t6c_en_drop");    add(0, 0, Z, "t6c_off_lo");
    addn(1, 0, Z, 8, "t6c_no_short");

    nreset = 1'b0;
    en     = 1'b1;
    in     = 1'b0;
    #12;
    check("reset_dut", dut_o, Z);
    check("reset_nd", nd_o, Z);
    @(negedge clk);
    nreset = 1'b1;
    step(1, 0);
    check("idle_after_reset", dut_o, Z);

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].en, vecs[k].in);
      check(vecs[k].tag, dut_o, vecs[k].exp);
    end

    // 5: asynchronous reset while waiting for a second press
    step(1, 1);
    check("t5_press", dut_o, P | H);
    step(1, 0);
    check("t5_release", dut_o, R);
    #2 nreset = 1'b0;
    #1 check("t5_async_clear", dut_o, Z);
    for (int k = 0; k < 2; k++) begin
      step(1, 0);
      check("t5_in_reset", dut_o, Z);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1, 0);
      check("t5_no_short", dut_o, Z);
    end

    // 6d: DOUBLE_CYCLES=0 build reports short_press with the release
    step(1, 1);
    check("t6d_press", nd_o, P | H);
    step(1, 1);
    check("t6d_hold", nd_o, H);
    step(1, 1);
    check("t6d_hold", nd_o, H);
    step(1, 0);
    check("t6d_release_short", nd_o, R | S);
    step(1, 0);
    check("t6d_quiet", nd_o, Z);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
